// File: rtl/instr_exec_checker_pkg.sv
// instr_exec_checker_pkg: FSM states and divider length for the execution checker
package instr_exec_checker_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, CALC, DIVIDE, OUTPUT, DONE} exec_state_t;
  localparam int DIV_CYCLES = 32;
endpackage

// File: rtl/instr_register_pkg.sv
// instr_register_pkg: shared instruction-register types
// opcode_t is 4 bits wide so encodings above MOD are representable (and treated as unknown)
package instr_register_pkg;
  typedef enum logic [3:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;
  typedef logic signed [31:0] operand_t;
  typedef logic signed [63:0] operand_res;
  typedef logic [4:0] address_t;
  typedef struct packed {
    opcode_t    opc;
    operand_t   op_a;
    operand_t   op_b;
    operand_res rezultat;
  } instruction_t;
endpackage

// File: rtl/seq_divider.sv
// seq_divider: 32-cycle signed shift-subtract divider (quotient toward zero, remainder signed like dividend)
// ports: clk, reset_n (sync, active-low), start, dividend, divisor -> quotient, remainder, div_done
module seq_divider
  import instr_register_pkg::*, instr_exec_checker_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     start,
  input  operand_t dividend,
  input  operand_t divisor,
  output operand_t quotient,
  output operand_t remainder,
  output logic     div_done
);
  logic [31:0] r_q, q_q, d_q, a_abs, b_abs, r_in, q_in, d_in, r_nx, q_nx;
  logic [32:0] sh;
  logic [5:0] cnt;
  logic run, neg_q, neg_r, ge;
  assign a_abs = dividend[31] ? -dividend : dividend;
  assign b_abs = divisor[31] ? -divisor : divisor;
  // the start edge already performs the first iteration so div_done lands 32 cycles after start
  always_comb begin
    r_in = start ? '0 : r_q;
    q_in = start ? a_abs : q_q;
    d_in = start ? b_abs : d_q;
    sh = {r_in, q_in[31]};
    ge = sh >= {1'b0, d_in};
    r_nx = ge ? 32'(sh - {1'b0, d_in}) : sh[31:0];
    q_nx = {q_in[30:0], ge};
  end
  assign div_done = run && cnt == 6'(DIV_CYCLES);
  assign quotient = neg_q ? -q_q : q_q;
  assign remainder = neg_r ? -r_q : r_q;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      run <= 1'b0;
      cnt <= '0;
      r_q <= '0;
      q_q <= '0;
      d_q <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= 6'd1;
      r_q <= r_nx;
      q_q <= q_nx;
      d_q <= b_abs;
      neg_q <= dividend[31] ^ divisor[31];
      neg_r <= dividend[31];
    end else if (div_done) begin
      run <= 1'b0;
    end else if (run) begin
      r_q <= r_nx;
      q_q <= q_nx;
      cnt <= cnt + 6'd1;
    end
  end
endmodule

// File: rtl/instr_exec_checker.sv
// instr_exec_checker: sweeps the instruction register, recomputes each result and streams it out
// ports: clk, reset_n (sync, active-low); start/first_ptr/last_ptr launch a sweep;
//        read_pointer/instruction_word read the register; res_* valid/ready result stream;
//        busy, done pulse, saturating err_count
// EXEC_SCOREBOARD_EN: builds the comparison against the stored rezultat (res_mismatch)
module instr_exec_checker
  import instr_register_pkg::*, instr_exec_checker_pkg::*;
#(
  parameter int NUM_WORDS = 32,
  parameter int ERR_W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  address_t     first_ptr,
  input  address_t     last_ptr,
  output address_t     read_pointer,
  input  instruction_t instruction_word,
  output logic         res_valid,
  input  logic         res_ready,
  output address_t     res_ptr,
  output opcode_t      res_opc,
  output operand_res   res_value,
  output logic         res_mismatch,
  output logic         res_div0,
  output logic         busy,
  output logic         done,
  output logic [ERR_W-1:0] err_count
);
  exec_state_t state, next_state;
  address_t last_q, next_ptr;
  opcode_t opc_q;
  operand_t a_q, b_q, quo, rem;
  operand_res calc_val, div_val;
  logic is_div, div0, div_start, div_done, hs, mm_calc, mm_div;
  assign is_div = opc_q inside {DIV, MOD};
  assign div0 = is_div && b_q == '0;
  assign div_start = state == CALC && is_div && !div0;
  assign hs = state == OUTPUT && res_ready;
  assign res_valid = state == OUTPUT;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign div_val = opc_q == MOD ? operand_res'(rem) : operand_res'(quo);
  assign next_ptr = read_pointer == address_t'(NUM_WORDS - 1) ? '0 : read_pointer + address_t'(1);
  always_comb begin
    calc_val = '0;
    case (opc_q)
      PASSA: calc_val = operand_res'(a_q);
      PASSB: calc_val = operand_res'(b_q);
      ADD:   calc_val = operand_res'(a_q) + operand_res'(b_q);
      SUB:   calc_val = operand_res'(a_q) - operand_res'(b_q);
      MULT:  calc_val = operand_res'(a_q) * operand_res'(b_q);
      default: calc_val = '0;
    endcase
  end
`ifdef EXEC_SCOREBOARD_EN
  operand_res rez_q;
  assign mm_calc = !(opc_q inside {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD}) || calc_val != rez_q;
  assign mm_div = div_val != rez_q;
  always_ff @(posedge clk) begin
    if (!reset_n) rez_q <= '0;
    else if (state == FETCH) rez_q <= instruction_word.rezultat;
  end
`else
  assign mm_calc = 1'b0;
  assign mm_div = 1'b0;
`endif
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = start ? FETCH : IDLE;
      FETCH:   next_state = CALC;
      CALC:    next_state = div_start ? DIVIDE : OUTPUT;
      DIVIDE:  next_state = div_done ? OUTPUT : DIVIDE;
      OUTPUT:  next_state = !res_ready ? OUTPUT : (read_pointer == last_q ? DONE : FETCH);
      default: next_state = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else state <= next_state;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      read_pointer <= '0;
      last_q <= '0;
      opc_q <= ZERO;
      a_q <= '0;
      b_q <= '0;
      res_ptr <= '0;
      res_opc <= ZERO;
      res_value <= '0;
      res_mismatch <= 1'b0;
      res_div0 <= 1'b0;
      err_count <= '0;
    end else begin
      if (state == IDLE && start) begin
        read_pointer <= first_ptr;
        last_q <= last_ptr;
        err_count <= '0;
      end
      if (state == FETCH) begin
        opc_q <= instruction_word.opc;
        a_q <= instruction_word.op_a;
        b_q <= instruction_word.op_b;
      end
      if ((state == CALC && !div_start) || (state == DIVIDE && div_done)) begin
        res_ptr <= read_pointer;
        res_opc <= opc_q;
        res_value <= state == CALC ? calc_val : div_val;
        res_mismatch <= state == CALC ? mm_calc : mm_div;
        res_div0 <= state == CALC && div0;
      end
      if (hs) begin
        if (read_pointer != last_q) read_pointer <= next_ptr;
        if ((res_mismatch || res_div0) && !(&err_count)) err_count <= err_count + ERR_W'(1);
      end
    end
  end
  seq_divider u_div (
    .clk(clk),
    .reset_n(reset_n),
    .start(div_start),
    .dividend(a_q),
    .divisor(b_q),
    .quotient(quo),
    .remainder(rem),
    .div_done(div_done)
  );
endmodule

// File: tb/tb_instr_exec_checker.sv
// tb_instr_exec_checker: randomized sweeps scored against a behavioural model of the checker
module tb_instr_exec_checker;
  import instr_register_pkg::*;
`ifdef EXEC_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif
  localparam int NW = 32;
  typedef struct {
    address_t   ptr;
    opcode_t    opc;
    operand_res val;
    logic       mm;
    logic       d0;
  } exp_t;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, res_ready = 1'b0;
  address_t first_ptr = '0, last_ptr = '0, read_pointer, res_ptr;
  instruction_t instruction_word;
  instruction_t mem [NW];
  logic res_valid, res_mismatch, res_div0, busy, done;
  opcode_t res_opc;
  operand_res res_value;
  logic [15:0] err_count;
  int checks = 0, errors = 0, model_err = 0;
  exp_t exp_q[$];
  always #5 clk = ~clk;
  assign instruction_word = mem[read_pointer];
  instr_exec_checker dut (
    .clk(clk), .reset_n(reset_n), .start(start), .first_ptr(first_ptr), .last_ptr(last_ptr),
    .read_pointer(read_pointer), .instruction_word(instruction_word),
    .res_valid(res_valid), .res_ready(res_ready), .res_ptr(res_ptr), .res_opc(res_opc),
    .res_value(res_value), .res_mismatch(res_mismatch), .res_div0(res_div0),
    .busy(busy), .done(done), .err_count(err_count)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, $signed(got), got, $signed(exp), exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic void model(input instruction_t w, output operand_res v, output logic mm, output logic d0);
    int a, b;
    bit known;
    a = w.op_a;
    b = w.op_b;
    known = 1'b1;
    d0 = 1'b0;
    case (w.opc)
      ZERO:  v = 0;
      PASSA: v = a;
      PASSB: v = b;
      ADD:   v = longint'(a) + longint'(b);
      SUB:   v = longint'(a) - longint'(b);
      MULT:  v = longint'(a) * longint'(b);
      DIV:   if (b == 0) begin v = 0; d0 = 1'b1; end else v = a / b;
      MOD:   if (b == 0) begin v = 0; d0 = 1'b1; end else v = a % b;
      default: begin v = 0; known = 1'b0; end
    endcase
    mm = SB && (!known || v != w.rezultat);
  endfunction
  function automatic instruction_t rand_word();
    instruction_t w;
    operand_res v;
    logic mm, d0;
    w.opc = opcode_t'($urandom_range(0, 8));
    w.op_a = int'($urandom_range(0, 2000)) - 1000;
    w.op_b = int'($urandom_range(0, 20)) - 10;
    w.rezultat = {$urandom, $urandom};
    model(w, v, mm, d0);
    if ($urandom_range(1) == 1) w.rezultat = v;
    return w;
  endfunction
  task automatic sweep(input address_t f, input address_t l, input int rdy_pct, input bit poke, input int exp_lat);
    int cyc, lat, p;
    exp_t e;
    operand_res v;
    logic mm, d0;
    exp_q.delete();
    model_err = 0;
    p = f;
    forever begin
      model(mem[p], v, mm, d0);
      exp_q.push_back('{address_t'(p), mem[p].opc, v, mm, d0});
      if ((mm || d0) && model_err < 65535) model_err++;
      if (p == int'(l)) break;
      p = (p + 1) % NW;
    end
    first_ptr = f;
    last_ptr = l;
    start = 1'b1;
    res_ready = 1'b0;
    tick();
    start = 1'b0;
    cyc = 1;
    lat = -1;
    while (exp_q.size() > 0 && cyc < 5000) begin
      start = poke && cyc == 4;
      first_ptr = poke && cyc == 4 ? f + address_t'(5) : f;
      if (res_valid) begin
        if (lat < 0) lat = cyc;
        e = exp_q[0];
        check("res_ptr", res_ptr, e.ptr);
        check("res_opc", res_opc, e.opc);
        check("res_value", res_value, e.val);
        check("res_mismatch", res_mismatch, e.mm);
        check("res_div0", res_div0, e.d0);
        res_ready = $urandom_range(99) < rdy_pct;
        if (res_ready) void'(exp_q.pop_front());
      end else res_ready = $urandom_range(1) == 1;
      tick();
      cyc++;
    end
    start = 1'b0;
    res_ready = 1'b0;
    check("sweep_timeout", exp_q.size(), 0);
    if (exp_lat > 0) check("latency", lat, exp_lat);
    check("done_pulse", done, 1);
    check("res_valid_in_done", res_valid, 0);
    check("err_count", err_count, model_err);
    tick();
    check("done_cleared", done, 0);
    check("busy_idle", busy, 0);
  endtask
  initial begin
    for (int i = 0; i < NW; i++) mem[i] = rand_word();
    mem[3] = '{opc: ADD, op_a: 5, op_b: 7, rezultat: 12};
    mem[0] = '{opc: MULT, op_a: -3, op_b: 100000, rezultat: 0};
    mem[1] = '{opc: DIV, op_a: -7, op_b: 2, rezultat: -3};
    mem[2] = '{opc: MOD, op_a: -7, op_b: 2, rezultat: -1};
    mem[4] = '{opc: DIV, op_a: 9, op_b: 0, rezultat: 0};
    mem[5] = '{opc: DIV, op_a: 100, op_b: 7, rezultat: 14};
    mem[6] = '{opc: opcode_t'(4'd12), op_a: 1, op_b: 2, rezultat: 0};
    tick();
    tick();
    check("rst_res_valid", res_valid, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_err_count", err_count, 0);
    check("rst_read_pointer", read_pointer, 0);
    check("rst_res_value", res_value, 0);
    check("rst_res_mismatch", res_mismatch, 0);
    check("rst_res_div0", res_div0, 0);
    reset_n = 1'b1;
    tick();
    sweep(3, 3, 100, 0, 3);
    sweep(0, 0, 100, 0, 3);
    sweep(1, 2, 100, 0, 35);
    sweep(4, 4, 100, 0, 3);
    sweep(6, 6, 100, 0, 3);
    sweep(30, 1, 50, 1, -1);
    for (int i = 0; i < 6; i++) sweep(address_t'($urandom_range(0, 31)), address_t'($urandom_range(0, 31)), 70, 0, -1);
    first_ptr = 4;
    last_ptr = 5;
    start = 1'b1;
    res_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check("mid_div_busy", busy, 1);
    check("mid_div_valid", res_valid, 0);
    check("mid_div_err_count", err_count, 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("rst_div_valid", res_valid, 0);
    check("rst_div_busy", busy, 0);
    check("rst_div_err_count", err_count, 0);
    tick();
    check("post_rst_idle", busy, 0);
    res_ready = 1'b0;
    sweep(5, 5, 100, 0, 35);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
